// File: rtl/gf_ops_pkg.sv
// Shared types for the GF operations datapath: FSM states, operation mode
// encoding and the digit-count helper.
package gf_ops_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StMult,
        StRed,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpAdd,
        OpMul,
        OpSqr
    } op_e;

    typedef enum logic {
        ArithClmul = 1'b0,
        ArithInt   = 1'b1
    } arith_e;

    typedef struct packed {
        op_e    op;
        arith_e arith;
    } mode_t;

    function automatic int unsigned num_digits(int unsigned w, int unsigned k);
        return w / k;
    endfunction

endpackage

// File: rtl/gf_digit_mac.sv
// Combinational digit multiply-accumulate: acc + (multiplicand * digit) << (K*idx),
// in integer or carry-less (XOR) arithmetic.
module gf_digit_mac #(
    parameter int unsigned W  = 32,
    parameter int unsigned K  = 4,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]   multiplicand,
    input  logic [K-1:0]   digit,
    input  logic [2*W-1:0] acc,
    input  logic [IW-1:0]  idx,
    input  logic           carry_option,
    output logic [2*W-1:0] acc_next
);

    logic [2*W-1:0] mcand_ext;
    logic [2*W-1:0] pp_int;
    logic [2*W-1:0] pp_clmul;

    assign mcand_ext = {{W{1'b0}}, multiplicand};
    assign pp_int    = mcand_ext * {{(2*W-K){1'b0}}, digit};

    always_comb begin
        pp_clmul = '0;
        for (int j = 0; j < int'(K); j++) begin
            if (digit[j]) begin
                pp_clmul = pp_clmul ^ (mcand_ext << j);
            end
        end
    end

    always_comb begin
        if (carry_option) begin
            acc_next = acc + (pp_int << (K * idx));
        end else begin
            acc_next = acc ^ (pp_clmul << (K * idx));
        end
    end

endmodule

// File: rtl/seq_add_mult_exp.sv
// Digit-serial add / multiply / square in integer or GF(2) carry-less arithmetic.
// Define GF_REDUCE_EN to add the poly port and in-block reduction to GF(2^W).
module seq_add_mult_exp
    import gf_ops_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DIGIT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sum_funct,
    input  logic                    exp_funct,
    input  logic                    carry_option,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
`ifdef GF_REDUCE_EN
    input  logic [DATA_WIDTH-1:0]   poly,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [2*DATA_WIDTH-1:0] mult_out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned K  = DIGIT_WIDTH;
    localparam int unsigned D  = num_digits(W, K);
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CntLast = CW'(D - 1);

    state_e         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [W-1:0]   a_q, a_d, m_q, m_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   out_q, out_d;
    logic [2*W-1:0] mult_out_q, mult_out_d;

    logic [2*W-1:0] mac_next;
    logic [K-1:0]   digit;
    logic [W:0]     add_int;
    logic           int_mode;
    logic           ready;
    logic           red_sel;

    assign int_mode = (mode_q.arith == ArithInt);
    assign digit    = m_q[K*cnt_q +: K];
    assign add_int  = {1'b0, a_q} + {1'b0, m_q};
    assign ready    = (state_q == StIdle) || (state_q == StDone);

    gf_digit_mac #(
        .W  (W),
        .K  (K),
        .IW (CW)
    ) u_mac (
        .multiplicand (a_q),
        .digit        (digit),
        .acc          (acc_q),
        .idx          (cnt_q),
        .carry_option (int_mode),
        .acc_next     (mac_next)
    );

`ifdef GF_REDUCE_EN
    logic [W-1:0]   poly_q, poly_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [2*W-1:0] fold;

    assign red_sel = ~int_mode;

    // Fold K upper-half bits per cycle, MSB first, so each fold's spill into
    // lower upper-half bits is caught by a later step.
    always_comb begin
        int j;
        fold = acc_q;
        for (int m = 0; m < int'(K); m++) begin
            j = int'(W) - 1 - int'(K) * int'(cnt_q) - m;
            if (fold[int'(W) + j]) begin
                fold = fold ^ ({{W{1'b0}}, poly_q} << j) ^ ((2*W)'(1) << (int'(W) + j));
            end
        end
    end
`else
    assign red_sel = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        a_d        = a_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        mult_out_d = mult_out_q;
`ifdef GF_REDUCE_EN
        poly_d     = poly_q;
        prod_d     = prod_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    mode_d.op    = sum_funct ? OpAdd : (exp_funct ? OpSqr : OpMul);
                    mode_d.arith = arith_e'(carry_option);
                    a_d          = a;
                    m_d          = (exp_funct && !sum_funct) ? a : b;
                    cnt_d        = '0;
                    acc_d        = '0;
`ifdef GF_REDUCE_EN
                    poly_d       = poly;
`endif
                    state_d      = sum_funct ? StAdd : StMult;
                end
            end
            StAdd: begin
                if (int_mode) begin
                    out_d      = add_int[W-1:0];
                    mult_out_d = {{(W-1){1'b0}}, add_int};
                end else begin
                    out_d      = a_q ^ m_q;
                    mult_out_d = {{W{1'b0}}, a_q ^ m_q};
                end
                state_d = StDone;
            end
            StMult: begin
                acc_d = mac_next;
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (red_sel) begin
`ifdef GF_REDUCE_EN
                        prod_d = mac_next;
`endif
                        state_d = StRed;
                    end else begin
                        out_d      = mac_next[W-1:0];
                        mult_out_d = mac_next;
                        state_d    = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef GF_REDUCE_EN
            StRed: begin
                acc_d = fold;
                if (cnt_q == CntLast) begin
                    cnt_d      = '0;
                    out_d      = fold[W-1:0];
                    mult_out_d = prod_q;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            a_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            mult_out_q <= '0;
`ifdef GF_REDUCE_EN
            poly_q     <= '0;
            prod_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            mult_out_q <= mult_out_d;
`ifdef GF_REDUCE_EN
            poly_q     <= poly_d;
            prod_q     <= prod_d;
`endif
        end
    end

    assign busy     = (state_q == StAdd) || (state_q == StMult) || (state_q == StRed);
    assign done     = (state_q == StDone);
    assign out      = out_q;
    assign mult_out = mult_out_q;

endmodule

// File: tb/tb_seq_add_mult_exp.sv
// Scoreboard bench for seq_add_mult_exp at W=8, K=4 (D=2); follows GF_REDUCE_EN.
module tb_seq_add_mult_exp;

    localparam int W = 8;
    localparam int K = 4;
`ifdef GF_REDUCE_EN
    localparam int CL_C = 4;
`else
    localparam int CL_C = 2;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           sum_funct = 1'b0;
    logic           exp_funct = 1'b0;
    logic           carry_option = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   poly = 8'h1B;
    logic           busy;
    logic           done;
    logic [W-1:0]   out;
    logic [2*W-1:0] mult_out;

    seq_add_mult_exp #(
        .DATA_WIDTH  (W),
        .DIGIT_WIDTH (K)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sum_funct    (sum_funct),
        .exp_funct    (exp_funct),
        .carry_option (carry_option),
        .a            (a),
        .b            (b),
`ifdef GF_REDUCE_EN
        .poly         (poly),
`endif
        .busy         (busy),
        .done         (done),
        .out          (out),
        .mult_out     (mult_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [W-1:0]   eo;
        logic [2*W-1:0] em;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_out"}, 32'(out), 32'(e.eo));
                chk({e.name, "_mult_out"}, 32'(mult_out), 32'(e.em));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge while the DUT is ready; acceptance is at the next posedge.
    task automatic issue(input string name, input bit s, input bit x, input bit c,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] eo, input logic [2*W-1:0] em,
                         input int lat, input bit push);
        exp_t e;
        sum_funct    = s;
        exp_funct    = x;
        carry_option = c;
        a            = ia;
        b            = ib;
        start        = 1'b1;
        if (push) begin
            e.name = name;
            e.eo   = eo;
            e.em   = em;
            e.cyc  = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 20) chk({name, "_timeout"}, 32'(i), 32'(0));
    endtask

    initial begin
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_out", 32'(out), 32'(0));
        chk("reset_mult_out", 32'(mult_out), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Consecutive vectors are issued in the DONE cycle of the previous one.
        issue("int_mul_ff", 0, 0, 1, 8'hFF, 8'hFF, 8'h01, 16'hFE01, 2, 1);
        wait_done("int_mul_ff");
        issue("cl_mul_03", 0, 0, 0, 8'h03, 8'h03, 8'h05, 16'h0005, CL_C, 1);
        wait_done("cl_mul_03");
        issue("cl_sqr_0f", 0, 1, 0, 8'h0F, 8'hAA, 8'h55, 16'h0055, CL_C, 1);
        wait_done("cl_sqr_0f");
        issue("int_add", 1, 0, 1, 8'hF0, 8'h20, 8'h10, 16'h0110, 1, 1);
        wait_done("int_add");
        issue("cl_add", 1, 1, 0, 8'hF0, 8'h20, 8'hD0, 16'h00D0, 1, 1);
        wait_done("cl_add");
`ifdef GF_REDUCE_EN
        issue("cl_mul_57_83", 0, 0, 0, 8'h57, 8'h83, 8'hC1, 16'h2B79, CL_C, 1);
`else
        issue("cl_mul_57_83", 0, 0, 0, 8'h57, 8'h83, 8'h79, 16'h2B79, CL_C, 1);
`endif
        wait_done("cl_mul_57_83");
        issue("int_sqr_0f", 0, 1, 1, 8'h0F, 8'h33, 8'hE1, 16'h00E1, 2, 1);
        wait_done("int_sqr_0f");
        issue("int_mul_12_34", 0, 0, 1, 8'h12, 8'h34, 8'hA8, 16'h03A8, 2, 1);
        wait_done("int_mul_12_34");
        repeat (2) @(negedge clk);

        // start while busy is ignored, and input changes do not disturb the operands.
        issue("busy_ignore", 0, 0, 1, 8'hFF, 8'hFF, 8'h01, 16'hFE01, 2, 1);
        chk("busy_during_mult", 32'(busy), 32'(1));
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore");
        @(negedge clk);
        chk("idle_after_done", 32'(busy | done), 32'(0));

        // Reset mid-MULT: no done pulse, outputs cleared.
        issue("aborted", 0, 0, 1, 8'h12, 8'h34, 8'h00, 16'h0000, 2, 0);
        chk("busy_before_abort", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_out", 32'(out), 32'(0));
        chk("abort_mult_out", 32'(mult_out), 32'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_abort_mult_out", 32'(mult_out), 32'(0));

        issue("int_add_wrap", 1, 0, 1, 8'h01, 8'hFF, 8'h00, 16'h0100, 1, 1);
        wait_done("int_add_wrap");
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
